score_ctrl: RTL and testbench

Game-side controller for the score banner renderer. It owns the 8-bit score, runs the IDLE/PLAY/OVER game-score state machine, and converts the binary score to three BCD digits with a sequential shift-add-3 converter. The converted digits are published to the renderer only at the start of vertical blank, so the banner never changes mid-frame. It sits between the player/collision logic and the score renderer.

---
 rtl/score_ctrl.sv | 155 +++++++++++++++
 tb/tb_score_ctrl.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/score_ctrl.sv
// score_ctrl: score register, IDLE/PLAY/OVER game FSM, sequential double-dabble BCD converter
// and a vblank-gated digit latch. Define HIGH_SCORE_EN to add the o_high_score register.
module score_ctrl #(
    parameter int VBLANK_LINE = 480,
    parameter int MAX_SCORE   = 255
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_start,
    input  logic       i_step,
    input  logic       i_game_over,
    input  logic [9:0] i_vpos,
    output logic [7:0] o_score,
    output logic [3:0] o_digit_hundreds,
    output logic [3:0] o_digit_tens,
    output logic [3:0] o_digit_ones,
    output logic       o_playing,
`ifdef HIGH_SCORE_EN
    output logic [7:0] o_high_score,
`endif
    output logic       o_busy
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_PLAY  = 2'd1;
    localparam logic [1:0] S_OVER  = 2'd2;
    localparam logic       C_IDLE  = 1'b0;
    localparam logic       C_SHIFT = 1'b1;

    localparam logic [9:0] VBLANK_POS = 10'(VBLANK_LINE);
    localparam logic [7:0] SCORE_MAX  = 8'(MAX_SCORE);

    logic [1:0]  state_q, state_d;
    logic [7:0]  score_q, score_d;
    logic        dirty_q, dirty_d;
    logic        conv_state_q, conv_state_d;
    logic [2:0]  count_q, count_d;
    logic [19:0] shift_q, shift_d;
    logic [11:0] pending_q, pending_d;
    logic [11:0] digits_q, digits_d;
    logic [9:0]  vpos_q, vpos_d;

    logic [19:0] shift_adj;
    logic [19:0] shift_next;
    logic        conv_load;
    logic        vblank_evt;

    // Game FSM; game over beats start beats step.
    always_comb begin
        state_d = state_q;
        score_d = score_q;
        if (i_game_over) begin
            if (state_q == S_PLAY) begin
                state_d = S_OVER;
            end
        end else if (i_start) begin
            state_d = S_PLAY;
            score_d = '0;
        end else if (i_step && (state_q == S_PLAY) && (score_q < SCORE_MAX)) begin
            score_d = score_q + 8'd1;
        end
    end

    // One double-dabble iteration: add 3 to each BCD nibble >= 5, then shift left.
    for (genvar gi = 0; gi < 3; gi++) begin : g_adj
        logic [3:0] nib;
        assign nib = shift_q[8 + 4*gi +: 4];
        assign shift_adj[8 + 4*gi +: 4] = (nib >= 4'd5) ? (nib + 4'd3) : nib;
    end
    assign shift_adj[7:0] = shift_q[7:0];
    assign shift_next     = shift_adj << 1;

    assign conv_load = (conv_state_q == C_IDLE) && dirty_q;

    always_comb begin
        conv_state_d = conv_state_q;
        count_d      = count_q;
        shift_d      = shift_q;
        pending_d    = pending_q;
        if (conv_state_q == C_IDLE) begin
            if (dirty_q) begin
                conv_state_d = C_SHIFT;
                count_d      = 3'd0;
                shift_d      = {12'd0, score_q};
            end
        end else begin
            shift_d = shift_next;
            count_d = count_q + 3'd1;
            if (count_q == 3'd7) begin
                pending_d    = shift_next[19:8];
                conv_state_d = C_IDLE;
            end
        end
    end

    // A change landing on the load cycle must survive the clear.
    assign dirty_d = (score_d != score_q) || (dirty_q && !conv_load);

    assign vpos_d     = i_vpos;
    assign vblank_evt = (i_vpos == VBLANK_POS) && (vpos_q != VBLANK_POS);
    assign digits_d   = vblank_evt ? pending_q : digits_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= S_IDLE;
            score_q      <= '0;
            dirty_q      <= 1'b0;
            conv_state_q <= C_IDLE;
            count_q      <= '0;
            shift_q      <= '0;
            pending_q    <= '0;
            digits_q     <= '0;
            vpos_q       <= '0;
        end else begin
            state_q      <= state_d;
            score_q      <= score_d;
            dirty_q      <= dirty_d;
            conv_state_q <= conv_state_d;
            count_q      <= count_d;
            shift_q      <= shift_d;
            pending_q    <= pending_d;
            digits_q     <= digits_d;
            vpos_q       <= vpos_d;
        end
    end

`ifdef HIGH_SCORE_EN
    logic [7:0] high_score_q, high_score_d;

    always_comb begin
        high_score_d = high_score_q;
        if ((state_q == S_PLAY) && (state_d == S_OVER) && (score_q > high_score_q)) begin
            high_score_d = score_q;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            high_score_q <= '0;
        end else begin
            high_score_q <= high_score_d;
        end
    end

    assign o_high_score = high_score_q;
`endif

    assign o_score          = score_q;
    assign o_playing        = (state_q == S_PLAY);
    assign o_busy           = (conv_state_q == C_SHIFT);
    assign o_digit_hundreds = digits_q[11:8];
    assign o_digit_tens     = digits_q[7:4];
    assign o_digit_ones     = digits_q[3:0];

endmodule

// File: tb/tb_score_ctrl.sv
// Bench for score_ctrl: directed stimulus, digit updates checked by a queue-driven monitor
// that reacts to every change on the displayed digits.
module tb_score_ctrl;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b1;
    logic       start = 1'b0;
    logic       step  = 1'b0;
    logic       game_over = 1'b0;
    logic [9:0] vpos  = 10'd0;

    logic [7:0] score;
    logic [3:0] dig_h, dig_t, dig_o;
    logic       playing;
    logic       busy;
`ifdef HIGH_SCORE_EN
    logic [7:0] high_score;
`endif

    int checks = 0;
    int errors = 0;
    logic [11:0] exp_q[$];
    logic [11:0] prev_digits = 12'h000;

    score_ctrl dut (
        .i_clk            (clk),
        .i_rst_n          (rst_n),
        .i_start          (start),
        .i_step           (step),
        .i_game_over      (game_over),
        .i_vpos           (vpos),
        .o_score          (score),
        .o_digit_hundreds (dig_h),
        .o_digit_tens     (dig_t),
        .o_digit_ones     (dig_o),
        .o_playing        (playing),
`ifdef HIGH_SCORE_EN
        .o_high_score     (high_score),
`endif
        .o_busy           (busy)
    );

    always #5 clk = ~clk;

    // Monitor: every change of the displayed digits must match the oldest expected update.
    always @(negedge clk) begin
        logic [11:0] cur;
        logic [11:0] want;
        cur = {dig_h, dig_t, dig_o};
        if (cur != prev_digits) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL digits_unexpected: got %h expected %h (no update due)", cur, prev_digits);
            end else begin
                want = exp_q.pop_front();
                if (cur != want) begin
                    errors++;
                    $display("FAIL digits_update: got %h expected %h", cur, want);
                end else begin
                    $display("digits update %h ok", cur);
                end
            end
        end
        prev_digits = cur;
    end

    task automatic check(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, want);
        end else begin
            $display("check %s = %0d ok", name, got);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic pulse_step();
        step = 1'b1;
        tick(1);
        step = 1'b0;
    endtask

    task automatic steps(input int n);
        step = 1'b1;
        tick(n);
        step = 1'b0;
    endtask

    task automatic vblank();
        vpos = 10'd479;
        tick(1);
        vpos = 10'd480;
        tick(1);
        vpos = 10'd0;
        tick(2);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        #2 rst_n = 1'b0;
        #1;
        check("reset_score", int'(score), 0);
        check("reset_digits", int'({dig_h, dig_t, dig_o}), 0);
        check("reset_playing", int'(playing), 0);
        check("reset_busy", int'(busy), 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        tick(2);

        // Start and three steps, shown at the next vblank.
        pulse_start();
        check("start_playing", int'(playing), 1);
        check("start_score", int'(score), 0);
        steps(3);
        check("score_3", int'(score), 3);
        tick(30);
        exp_q.push_back(12'h003);
        vblank();

        // Step-to-pending latency from an idle converter.
        pulse_step();
        check("lat_busy_e0", int'(busy), 0);
        tick(1);
        check("lat_busy_e1", int'(busy), 1);
        tick(7);
        check("lat_busy_e8", int'(busy), 1);
        vpos = 10'd480;
        tick(1);
        check("lat_busy_e9", int'(busy), 0);
        vpos = 10'd0;
        tick(1);
        check("lat_digits_old", int'({dig_h, dig_t, dig_o}), 12'h003);
        exp_q.push_back(12'h004);
        vpos = 10'd480;
        tick(1);
        vpos = 10'd0;
        tick(2);

        // Saturation at 255.
        pulse_start();
        steps(300);
        check("score_sat", int'(score), 255);
        tick(30);
        exp_q.push_back(12'h255);
        vblank();

        // Frame gating and a single latch per frame.
        pulse_start();
        steps(9);
        tick(30);
        exp_q.push_back(12'h009);
        vblank();
        vpos = 10'd100;
        pulse_step();
        check("gate_score_now", int'(score), 10);
        tick(20);
        check("gate_digits_hold", int'({dig_h, dig_t, dig_o}), 12'h009);
        exp_q.push_back(12'h010);
        vpos = 10'd480;
        tick(50);
        pulse_step();
        tick(800);
        check("gate_one_latch", int'({dig_h, dig_t, dig_o}), 12'h010);
        vpos = 10'd0;
        tick(2);
        exp_q.push_back(12'h011);
        vblank();

        // Coincident pulses.
        pulse_start();
        steps(7);
        tick(30);
        exp_q.push_back(12'h007);
        vblank();
        step = 1'b1;
        game_over = 1'b1;
        tick(1);
        step = 1'b0;
        game_over = 1'b0;
        check("coinc_score", int'(score), 7);
        check("coinc_playing", int'(playing), 0);
        pulse_step();
        check("over_step_ignored", int'(score), 7);
        pulse_start();
        check("restart_score", int'(score), 0);
        check("restart_playing", int'(playing), 1);
        tick(30);
        exp_q.push_back(12'h000);
        vblank();

        // Asynchronous reset in the middle of a conversion.
        steps(2);
        tick(30);
        exp_q.push_back(12'h002);
        vblank();
        pulse_step();
        tick(4);
        check("midconv_busy", int'(busy), 1);
        exp_q.push_back(12'h000);
        rst_n = 1'b0;
        #1;
        check("rst_busy", int'(busy), 0);
        check("rst_score", int'(score), 0);
        check("rst_playing", int'(playing), 0);
        tick(3);
        check("rst_hold_busy", int'(busy), 0);
        check("rst_hold_digits", int'({dig_h, dig_t, dig_o}), 0);
        rst_n = 1'b1;
        tick(2);
        pulse_start();
        steps(5);
        check("post_rst_score", int'(score), 5);
        tick(30);
        exp_q.push_back(12'h005);
        vblank();

`ifdef HIGH_SCORE_EN
        exp_q.push_back(12'h000);
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(2);
        check("hs_reset", int'(high_score), 0);
        pulse_start();
        steps(12);
        game_over = 1'b1;
        tick(1);
        game_over = 1'b0;
        check("hs_first", int'(high_score), 12);
        pulse_start();
        check("hs_kept_on_start", int'(high_score), 12);
        steps(5);
        game_over = 1'b1;
        tick(1);
        game_over = 1'b0;
        check("hs_second", int'(high_score), 12);
        check("hs_score", int'(score), 5);
        rst_n = 1'b0;
        tick(2);
        check("hs_after_reset", int'(high_score), 0);
        rst_n = 1'b1;
        tick(2);
`endif

        tick(5);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL digit_updates_outstanding: got %0d expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
